// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and state type for the LED display scan controller
package disp_pkg;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    // Active-low a..g in bits 7..1, dp (bit 0) left dark; entry k is the glyph for BCD k
    localparam logic [9:0][7:0] GLYPHS = {
        8'h09, 8'h01, 8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational BCD to active-low a..g decoder, non-BCD codes blank
module bcd_seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = bcd > 4'd9 ? 7'h7F : GLYPHS[bcd][7:1];
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed common-anode scan with ghost blanking,
// leading-zero suppression, decimal points and blink, one frame captured at a time
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_DIV    = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_blank_en,
    output logic [7:0]            seg_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic [4*N_DIGITS-1:0] sh_dig;
    logic [N_DIGITS-1:0]   sh_dp, sh_blink, lz;
    logic                  sh_lz, run, last, tick, show;
    logic [6:0]            glyph;

    // lz[k] is set when digit k and everything above it is zero
    always_comb begin
        run = sh_lz;
        lz = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            run = run && sh_dig[4*k +: 4] == 4'd0;
            lz[k] = run;
        end
    end

    bcd_seg_decode u_dec (.bcd(sh_dig[4*idx +: 4]), .seg(glyph));

    assign last = cnt == CW'(SCAN_DIV - 1);
    assign tick = state == DRIVE && last && idx == IW'(N_DIGITS - 1);
    assign show = state == DRIVE && !(phase && sh_blink[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            fcnt <= '0;
            phase <= 1'b0;
            {sh_dig, sh_dp, sh_blink, sh_lz} <= '0;
            seg_o <= SEG_BLANK;
            an_o <= '1;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            fcnt <= '0;
            phase <= 1'b0;
            seg_o <= SEG_BLANK;
            an_o <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick;
            seg_o <= show ? {lz[idx] ? 7'h7F : glyph, ~sh_dp[idx]} : SEG_BLANK;
            an_o <= show ? ~(N_DIGITS'(1) << idx) : '1;
            // Shadow capture only at frame start so a frame never mixes two input words
            if (state == IDLE || tick)
                {sh_dig, sh_dp, sh_blink, sh_lz} <= {digits_i, dp_mask, blink_mask, lz_blank_en};
            if (tick) begin
                fcnt <= fcnt == FW'(BLINK_DIV - 1) ? '0 : fcnt + 1'b1;
                if (fcnt == FW'(BLINK_DIV - 1)) phase <= ~phase;
            end
            case (state)
                IDLE: begin
                    state <= BLANK;
                    cnt <= '0;
                    idx <= '0;
                end
                BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(BLANK_CYCLES - 1)) state <= DRIVE;
                end
                default: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state <= BLANK;
                        idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: table vectors, corner sequences and a position-based
// reference model of the scan controller checked every cycle
module tb_disp_scan_ctrl;
    localparam int N = 4, SD = 8, BC = 2, BD = 2, FRAME = SD * N;
    localparam logic [7:0] REF_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    logic clk = 0, rst_n = 0, enable = 0, lz_blank_en = 0;
    logic [15:0] digits_i = '0;
    logic [3:0] dp_mask = '0, blink_mask = '0, an_o;
    logic [7:0] seg_o;
    logic frame_tick;
    int checks = 0, errors = 0;

    disp_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .digits_i(digits_i), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .lz_blank_en(lz_blank_en), .seg_o(seg_o), .an_o(an_o),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Expected outputs from the position p of the cycle within the scan since enable
    function automatic logic [12:0] ref_out(int p, logic [15:0] dig, logic [3:0] dp, logic [3:0] bl, logic lz);
        int c, d;
        logic [3:0] v;
        logic [7:0] seg;
        logic sup, ph, on;
        c = p % SD;
        d = (p / SD) % N;
        ph = ((p / FRAME) / BD) % 2 == 1;
        v = 4'((dig >> (4 * d)) & 16'hF);
        sup = lz && d >= 1 && (dig >> (4 * d)) == 16'd0;
        seg = {sup ? 7'h7F : REF_GLYPH[v][7:1], ~dp[d]};
        on = c >= BC && !(ph && bl[d]);
        return {c == SD - 1 && d == N - 1, on ? ~(4'b1 << d) : 4'hF, on ? seg : 8'hFF};
    endfunction

    logic [15:0] m_dig;
    logic [3:0] m_dp, m_bl, exp_an = 4'hF;
    logic m_lz, run = 0, exp_ft = 0;
    logic [7:0] exp_seg = 8'hFF;
    int pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !enable) begin
            run <= 0;
            {exp_ft, exp_an, exp_seg} <= {1'b0, 4'hF, 8'hFF};
        end else if (!run) begin
            run <= 1;
            pos <= -1;
            {exp_ft, exp_an, exp_seg} <= {1'b0, 4'hF, 8'hFF};
            {m_dig, m_dp, m_bl, m_lz} <= {digits_i, dp_mask, blink_mask, lz_blank_en};
        end else begin
            pos <= pos + 1;
            {exp_ft, exp_an, exp_seg} <= ref_out(pos + 1, m_dig, m_dp, m_bl, m_lz);
            if ((pos + 1) % FRAME == FRAME - 1)
                {m_dig, m_dp, m_bl, m_lz} <= {digits_i, dp_mask, blink_mask, lz_blank_en};
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("model seg", seg_o, exp_seg);
        chk("model an", an_o, exp_an);
        chk("model frame_tick", frame_tick, exp_ft);
    endtask

    task automatic restart();
        enable = 0;
        tick();
        enable = 1;
    endtask

    task automatic wait_an(input logic [3:0] pat, input string name);
        logic ok;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            ok = an_o == pat;
        end
        chk(name, ok, 1'b1);
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0] dp, bl;
        logic lz;
        logic [3:0][7:0] seg;
    } vec_t;
    vec_t vecs [9];

    initial begin
        logic [3:0][7:0] got;
        logic seen;
        int n;
        vecs[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
        vecs[1] = '{16'h0007, 4'h0, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h1F}};
        vecs[2] = '{16'h0007, 4'h0, 4'h0, 1'b0, {8'h03, 8'h03, 8'h03, 8'h1F}};
        vecs[3] = '{16'h12A4, 4'h4, 4'h0, 1'b0, {8'h9F, 8'h24, 8'hFF, 8'h99}};
        vecs[4] = '{16'h0000, 4'h0, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h03}};
        vecs[5] = '{16'h0890, 4'h8, 4'h0, 1'b1, {8'hFE, 8'h01, 8'h09, 8'h03}};
        vecs[6] = '{16'h5678, 4'h0, 4'h0, 1'b0, {8'h49, 8'h41, 8'h1F, 8'h01}};
        vecs[7] = '{16'hFEDC, 4'hF, 4'h0, 1'b0, {8'hFE, 8'hFE, 8'hFE, 8'hFE}};
        vecs[8] = '{16'h0102, 4'h0, 4'h0, 1'b1, {8'hFF, 8'h9F, 8'h03, 8'h25}};

        repeat (3) tick();
        chk("reset seg", seg_o, 8'hFF);
        chk("reset an", an_o, 4'hF);
        chk("reset frame_tick", frame_tick, 1'b0);
        rst_n = 1;

        foreach (vecs[i]) begin
            {digits_i, dp_mask, blink_mask, lz_blank_en} = {vecs[i].dig, vecs[i].dp, vecs[i].bl, vecs[i].lz};
            restart();
            got = 'x;
            for (int t = 0; t < 40; t++) begin
                tick();
                for (int d = 0; d < N; d++) if (an_o == ~(4'b1 << d)) got[d] = seg_o;
            end
            for (int d = 0; d < N; d++) chk($sformatf("vec%0d digit%0d", i, d), got[d], vecs[i].seg[d]);
        end

        {digits_i, dp_mask, blink_mask, lz_blank_en} = {16'h1234, 4'h0, 4'h0, 1'b0};
        restart();
        wait_an(4'b1011, "torn wait d2");
        digits_i = 16'h5678;
        wait_an(4'b0111, "torn wait d3");
        chk("torn old frame d3", seg_o, 8'h9F);
        wait_an(4'b1110, "torn wait next d0");
        chk("torn new frame d0", seg_o, 8'h01);

        digits_i = 16'h1234;
        restart();
        n = 0;
        for (int i = 0; i < 64 && !frame_tick; i++) tick();
        chk("first frame_tick", frame_tick, 1'b1);
        do begin tick(); n++; end while (!frame_tick && n < 64);
        chk("frame_tick period", n, FRAME);

        wait_an(4'b1101, "disable wait drive");
        enable = 0;
        tick();
        chk("disable an", an_o, 4'hF);
        chk("disable seg", seg_o, 8'hFF);
        enable = 1;
        repeat (3) tick();
        chk("restart still blank", an_o, 4'hF);
        tick();
        chk("restart digit0", an_o, 4'b1110);

        blink_mask = 4'b1100;
        restart();
        for (int f = 0; f < 6; f++) begin
            seen = 0;
            n = 0;
            do begin tick(); n++; seen |= an_o[3:2] != 2'b11; end while (!frame_tick && n < 40);
            chk($sformatf("blink frame%0d upper lit", f), seen, f != 2 && f != 3);
        end

        restart();
        repeat (70) tick();
        wait_an(4'b1101, "reset wait drive");
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async reset an", an_o, 4'hF);
        chk("async reset seg", seg_o, 8'hFF);
        chk("async reset frame_tick", frame_tick, 1'b0);
        repeat (3) tick();
        rst_n = 1;
        wait_an(4'b0111, "post reset phase cleared");

        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0)
                digits_i = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            if ($urandom_range(0, 59) == 0)
                {dp_mask, blink_mask, lz_blank_en} = 9'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                enable = 0;
                repeat ($urandom_range(1, 3)) tick();
                enable = 1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
